// File: rtl/rega_countdown.sv
// Four-digit BCD MM:SS countdown timer for the irrigation cycle.
// The preset is captured on load, counts down on each tick while running, and pulses done at 00:00.
module rega_countdown (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] preset_dm,
   input  logic [3:0] preset_um,
   input  logic [3:0] preset_ds,
   input  logic [3:0] preset_us,
   output logic [3:0] dm,
   output logic [3:0] um,
   output logic [3:0] ds,
   output logic [3:0] us,
   output logic       valve,
   output logic       done,
   output logic       armed
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q;
   logic [3:0] dm_q, um_q, ds_q, us_q;

   logic [3:0] clamp_dm_d, clamp_um_d, clamp_ds_d, clamp_us_d;
   logic       clamp_zero;
   logic [3:0] dec_dm_d, dec_um_d, dec_ds_d, dec_us_d;
   logic       dec_zero;

   always_comb begin
      clamp_dm_d = (preset_dm > 4'd9) ? 4'd9 : preset_dm;
      clamp_um_d = (preset_um > 4'd9) ? 4'd9 : preset_um;
      clamp_ds_d = (preset_ds > 4'd5) ? 4'd5 : preset_ds;
      clamp_us_d = (preset_us > 4'd9) ? 4'd9 : preset_us;
      clamp_zero = (clamp_dm_d == 4'd0) && (clamp_um_d == 4'd0) &&
                   (clamp_ds_d == 4'd0) && (clamp_us_d == 4'd0);
   end

   // Borrow ripples from seconds-units upward; dm cannot underflow because 00:00 is never decremented.
   always_comb begin
      dec_dm_d = dm_q;
      dec_um_d = um_q;
      dec_ds_d = ds_q;
      dec_us_d = us_q - 4'd1;
      if (us_q == 4'd0) begin
         dec_us_d = 4'd9;
         dec_ds_d = ds_q - 4'd1;
         if (ds_q == 4'd0) begin
            dec_ds_d = 4'd5;
            dec_um_d = um_q - 4'd1;
            if (um_q == 4'd0) begin
               dec_um_d = 4'd9;
               dec_dm_d = dm_q - 4'd1;
            end
         end
      end
      dec_zero = (dm_q == 4'd0) && (um_q == 4'd0) && (ds_q == 4'd0) && (us_q == 4'd1);
   end

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_q <= IDLE;
         dm_q    <= 4'd0;
         um_q    <= 4'd0;
         ds_q    <= 4'd0;
         us_q    <= 4'd0;
      end else begin
         case (state_q)
            IDLE, ARMED: begin
               if (load) begin
                  dm_q    <= clamp_dm_d;
                  um_q    <= clamp_um_d;
                  ds_q    <= clamp_ds_d;
                  us_q    <= clamp_us_d;
                  state_q <= clamp_zero ? IDLE : ARMED;
               end else if (start && (state_q == ARMED)) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  dm_q <= dec_dm_d;
                  um_q <= dec_um_d;
                  ds_q <= dec_ds_d;
                  us_q <= dec_us_d;
                  if (dec_zero) begin
                     state_q <= DONE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               dm_q    <= 4'd0;
               um_q    <= 4'd0;
               ds_q    <= 4'd0;
               us_q    <= 4'd0;
            end
         endcase
      end
   end

   assign dm    = dm_q;
   assign um    = um_q;
   assign ds    = ds_q;
   assign us    = us_q;
   assign valve = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_rega_countdown.sv
// Bench for rega_countdown: directed vector table, a completion sequence, and random stimulus
// checked against a seconds-based reference model.
module tb_rega_countdown;

   logic       clk = 1'b0;
   logic       rst, tick, load, start, abort;
   logic [3:0] preset_dm, preset_um, preset_ds, preset_us;
   logic [3:0] dm, um, ds, us;
   logic       valve, done, armed;

   always #5 clk = ~clk;

   rega_countdown dut (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .start(start), .abort(abort),
      .preset_dm(preset_dm), .preset_um(preset_um), .preset_ds(preset_ds), .preset_us(preset_us),
      .dm(dm), .um(um), .ds(ds), .us(us),
      .valve(valve), .done(done), .armed(armed)
   );

   typedef struct {
      logic        r, t, l, s, a;
      logic [15:0] p;
      logic [15:0] exp_digits;
      logic        exp_valve, exp_done, exp_armed;
   } vec_t;

   vec_t vecs[$];

   // Reference model: phase 0=idle 1=armed 2=running 3=finished, time kept as total seconds.
   int m_phase = 0;
   int m_secs  = 0;
   int n_pass  = 0;
   int n_checks = 0;

   function automatic int preset_to_secs(input logic [15:0] p);
      int d_m, u_m, d_s, u_s;
      d_m = (int'(p[15:12]) > 9) ? 9 : int'(p[15:12]);
      u_m = (int'(p[11:8])  > 9) ? 9 : int'(p[11:8]);
      d_s = (int'(p[7:4])   > 5) ? 5 : int'(p[7:4]);
      u_s = (int'(p[3:0])   > 9) ? 9 : int'(p[3:0]);
      return d_m * 600 + u_m * 60 + d_s * 10 + u_s;
   endfunction

   function automatic logic [15:0] secs_to_bcd(input int s);
      logic [3:0] a, b, c, d;
      a = 4'(s / 600);
      b = 4'((s / 60) % 10);
      c = 4'((s % 60) / 10);
      d = 4'(s % 10);
      return {a, b, c, d};
   endfunction

   function automatic logic [18:0] model_out();
      return {secs_to_bcd(m_secs), (m_phase == 2), (m_phase == 3), (m_phase == 1)};
   endfunction

   task automatic model_step(input logic r, t, l, s, a, input logic [15:0] p);
      if (r || a) begin
         m_phase = 0;
         m_secs  = 0;
      end else if (m_phase == 3) begin
         m_phase = 0;
         m_secs  = 0;
      end else if (m_phase == 2) begin
         if (t) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) m_phase = 3;
         end
      end else if (l) begin
         m_secs  = preset_to_secs(p);
         m_phase = (m_secs == 0) ? 0 : 1;
      end else if (m_phase == 1 && s) begin
         m_phase = 2;
      end
   endtask

   task automatic step(input logic r, t, l, s, a, input logic [15:0] p);
      rst = r; tick = t; load = l; start = s; abort = a;
      {preset_dm, preset_um, preset_ds, preset_us} = p;
      @(posedge clk);
      model_step(r, t, l, s, a, p);
      #1;
   endtask

   task automatic check(input string name, input logic [18:0] exp);
      logic [18:0] act;
      act = {dm, um, ds, us, valve, done, armed};
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got digits=%h valve=%b done=%b armed=%b, expected digits=%h valve=%b done=%b armed=%b",
                    name, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
   endtask

   task automatic addv(input logic r, t, l, s, a, input logic [15:0] p,
                       input logic [15:0] ed, input logic ev, edn, ea);
      vec_t v;
      v.r = r; v.t = t; v.l = l; v.s = s; v.a = a; v.p = p;
      v.exp_digits = ed; v.exp_valve = ev; v.exp_done = edn; v.exp_armed = ea;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; abort = 1'b0;
      {preset_dm, preset_um, preset_ds, preset_us} = 16'h0000;

      //    r  t  l  s  a  preset            digits    v  d  a
      addv(1, 1, 1, 1, 0, 16'($urandom),     16'h0000, 0, 0, 0);
      addv(0, 0, 0, 1, 0, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'h1230,          16'h1230, 0, 0, 1);
      addv(0, 0, 0, 1, 0, 16'h0000,          16'h1230, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h1229, 1, 0, 0);
      addv(0, 0, 0, 0, 0, 16'h0000,          16'h1229, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h1228, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h1227, 1, 0, 0);
      addv(0, 0, 1, 1, 0, 16'h0000,          16'h1227, 1, 0, 0);
      addv(0, 0, 0, 0, 1, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'h1000,          16'h1000, 0, 0, 1);
      addv(0, 0, 0, 1, 0, 16'h0000,          16'h1000, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h0959, 1, 0, 0);
      addv(0, 0, 0, 0, 1, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'h0100,          16'h0100, 0, 0, 1);
      addv(0, 1, 0, 1, 0, 16'h0000,          16'h0100, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h0059, 1, 0, 0);
      addv(0, 0, 0, 0, 1, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'h0002,          16'h0002, 0, 0, 1);
      addv(0, 0, 0, 1, 0, 16'h0000,          16'h0002, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h0001, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h0000, 0, 1, 0);
      addv(0, 1, 1, 1, 0, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'hAF7C,          16'h9959, 0, 0, 1);
      addv(0, 0, 1, 0, 0, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'h0300,          16'h0300, 0, 0, 1);
      addv(0, 0, 1, 1, 0, 16'h0145,          16'h0145, 0, 0, 1);
      addv(0, 0, 0, 1, 0, 16'h0000,          16'h0145, 1, 0, 0);
      addv(1, 1, 0, 0, 0, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 0, 0, 0, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 1, 0, 0, 16'h0518,          16'h0518, 0, 0, 1);
      addv(0, 0, 0, 1, 0, 16'h0000,          16'h0518, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 16'h0000,          16'h0517, 1, 0, 0);
      addv(0, 1, 0, 0, 1, 16'h0000,          16'h0000, 0, 0, 0);
      addv(0, 0, 0, 0, 0, 16'h0000,          16'h0000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].r, vecs[i].t, vecs[i].l, vecs[i].s, vecs[i].a, vecs[i].p);
         $display("vec %0d: r=%b t=%b l=%b s=%b a=%b p=%h -> %h%h:%h%h valve=%b done=%b armed=%b",
                  i, vecs[i].r, vecs[i].t, vecs[i].l, vecs[i].s, vecs[i].a, vecs[i].p,
                  dm, um, ds, us, valve, done, armed);
         check($sformatf("vec%0d", i),
               {vecs[i].exp_digits, vecs[i].exp_valve, vecs[i].exp_done, vecs[i].exp_armed});
      end

      // Completion from 00:01 with idle gaps between ticks: done must be a single-cycle pulse.
      step(0, 0, 1, 0, 0, 16'h0001);
      check("seq_load_0001", {16'h0001, 1'b0, 1'b0, 1'b1});
      step(0, 0, 0, 1, 0, 16'h0000);
      check("seq_start", {16'h0001, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0, 16'h0000);
         check("seq_pause_hold", {16'h0001, 1'b1, 1'b0, 1'b0});
      end
      step(0, 1, 0, 0, 0, 16'h0000);
      check("seq_terminal_done", {16'h0000, 1'b0, 1'b1, 1'b0});
      step(0, 1, 0, 1, 0, 16'h0000);
      check("seq_after_done_idle", {16'h0000, 1'b0, 1'b0, 1'b0});
      step(0, 0, 0, 0, 0, 16'h0000);
      check("seq_idle_stays", {16'h0000, 1'b0, 1'b0, 1'b0});

      // Random stimulus against the model.
      for (int i = 0; i < 4000; i++) begin
         logic        r, t, l, s, a;
         logic [15:0] p;
         r = ($urandom_range(0, 299) == 0);
         a = ($urandom_range(0, 149) == 0);
         l = ($urandom_range(0, 11) == 0);
         s = ($urandom_range(0, 5) == 0);
         t = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 2) == 0) p = {12'h000, 4'($urandom_range(0, 3))};
         else if ($urandom_range(0, 1) == 0) p = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom)};
         else p = 16'($urandom);
         step(r, t, l, s, a, p);
         check($sformatf("rand%0d", i), model_out());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rega_countdown.md
# rega_countdown

Four-digit BCD MM:SS countdown stage that consumes the per-digit preset values produced by the watering-time preset logic and times the irrigation cycle. It captures the preset on a load strobe, counts down once per 1 Hz tick while running, drives the valve enable, and pulses done at 00:00. The digit outputs feed the 7-segment display decoders.

## Interface

Parameters: none.

- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle pulse per second (clock-enable for counting)
- load  input  1  capture preset digits (one-cycle strobe)
- start  input  1  begin countdown from the loaded value
- abort  input  1  stop and clear the timer
- preset_dm  input  4  minutes-tens preset (BCD)
- preset_um  input  4  minutes-units preset (BCD)
- preset_ds  input  4  seconds-tens preset (BCD)
- preset_us  input  4  seconds-units preset (BCD)
- dm, um, ds, us  output  4 each  current digit values (registered)
- valve  output  1  1 while counting (state RUN)
- done  output  1  one-cycle pulse when the count reaches 00:00
- armed  output  1  1 in state ARMED

## Operation

- States: IDLE, ARMED, RUN, DONE.
- IDLE: on load, capture clamped presets; if the captured value is non-zero go to ARMED, else stay in IDLE with the digits at 00:00. start and tick are ignored.
- ARMED: load re-captures (same zero rule; zero goes to IDLE). start goes to RUN. tick is ignored.
- RUN: on tick, decrement MM:SS by one second. A decrement that yields 00:00 goes to DONE. load and start are ignored.
- DONE: lasts exactly one cycle, then IDLE. Digits stay at 00:00.
- abort, in any state: go to IDLE and clear the digits to 00:00.
- Clamping at capture: us > 9 becomes 9; ds > 5 becomes 5; um > 9 becomes 9; dm > 9 becomes 9.
- Decrement with borrow chain:
  - us: 0 becomes 9 and borrows.
  - ds: 0 becomes 5 and borrows.
  - um: 0 becomes 9 and borrows.
  - dm: decrements on borrow. It never underflows, because 00:00 is never decremented.
- Priority (high to low): rst, abort, load, start, tick.
  - load and start in the same ARMED cycle: load wins and the state stays ARMED.
  - start and tick in the same cycle: tick is ignored.
- Outputs:
  - valve = (state == RUN)
  - done = (state == DONE)
  - armed = (state == ARMED)
  - All outputs are registered or decoded directly from the state register.

## Timing

- Reset: state IDLE, all digits 0, valve 0, done 0, armed 0. Reset mid-RUN drops valve in the following cycle with no done pulse.
- load in cycle N: digits and armed are valid in cycle N+1.
- start in cycle N (state ARMED): valve = 1 from N+1.
- tick in cycle N (state RUN): the decremented digits appear in N+1.
- Terminal tick (00:01 becomes 00:00) in cycle N: in N+1, digits = 00:00, valve = 0, done = 1. In N+2, state is IDLE and done = 0.
- Pause between ticks: digits hold their values indefinitely.
- abort in cycle N: IDLE, 00:00, valve 0 in N+1. No done pulse.
- Maximum count is 99:59.

## Test plan

- Reset: assert rst with random inputs → all outputs 0 and state IDLE. Release with no load → digits hold 00:00 and start has no effect.
- Basic count: load 12:30, start, 3 ticks → digits 12:27, valve 1 throughout, done 0.
- Borrow chain: load 10:00, start, 1 tick → 09:59. Load 01:00, 1 tick → 00:59.
- Completion: load 00:02, start, 2 ticks → done high for exactly 1 cycle after the 2nd tick, valve falls in that same cycle, next cycle state IDLE, digits 00:00.
- Clamping and zero load: preset dm=A, um=F, ds=7, us=C → digits 99:59, armed 1. Load 00:00 → armed 0, state IDLE.
- Collisions and abort:
  - load and start together in ARMED → new value captured, valve 0.
  - abort during RUN at 05:17 → next cycle 00:00, valve 0, no done pulse.
  - rst mid-RUN → same result as abort.
